// File: rtl/tone_order_ctrl.sv
// tone_order_ctrl: walks the bit-loading table in index order and gathers
// each tone's bits from the fast/inter FIFOs. Readback port: TONE_CTRL_READBACK_EN.
module tone_order_ctrl #(
    parameter int DW        = 8,
    parameter int TABLELEN  = 64,
    parameter int CONFAW    = 8,
    parameter int CONFDW    = 8,
    parameter int CNUMW     = 8,
    parameter int MAXBITNUM = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we_conf_i,
    input  logic [CONFAW-1:0]    addr_i,
    input  logic [CONFDW-1:0]    conf_data_i,
`ifdef TONE_CTRL_READBACK_EN
    input  logic                 re_conf_i,
    output logic [CONFDW-1:0]    conf_rdata_o,
`endif
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    input  logic                 fast_empty_i,
    input  logic                 inter_empty_i,
    output logic                 fast_re_o,
    output logic                 inter_re_o,
    input  logic [DW-1:0]        fast_data_i,
    input  logic [DW-1:0]        inter_data_i,
    output logic                 tone_valid_o,
    input  logic                 tone_ready_i,
    output logic [CNUMW-1:0]     carrier_num_o,
    output logic [MAXBITNUM-1:0] bits_o,
    output logic [3:0]           bitcnt_o,
    output logic                 err_o
);

    localparam int IW = $clog2(TABLELEN);
    localparam int CW = $clog2(DW) + 1;
    localparam logic [CONFAW-1:0] A_CN   = CONFAW'(TABLELEN);
    localparam logic [CONFAW-1:0] A_USED = CONFAW'(2 * TABLELEN);
    localparam logic [CONFAW-1:0] A_FLO  = CONFAW'(2 * TABLELEN + 1);
    localparam logic [CONFAW-1:0] A_FHI  = CONFAW'(2 * TABLELEN + 2);

    typedef enum logic [2:0] {
        IDLE, LOAD, GATHER, WAIT_F, WAIT_I, EMIT, DONE
    } state_t;

    state_t r_state, w_next;

    logic [CONFDW-1:0]    r_bl_tbl [TABLELEN];
    logic [CNUMW-1:0]     r_cn_tbl [TABLELEN];
    logic [CONFDW-1:0]    r_used;
    logic [15:0]          r_fastbits;
    logic [15:0]          r_fast_rem;
    logic [IW-1:0]        r_idx;
    logic [DW-1:0]        r_fbuf, r_ibuf;
    logic [CW-1:0]        r_fcnt, r_icnt;
    logic [3:0]           r_n, r_gcnt;
    logic [MAXBITNUM-1:0] r_bits;
    logic [CNUMW-1:0]     r_carrier;
    logic                 r_busy, r_done, r_err;

    logic [IW-1:0]     w_tidx;
    logic              w_wr;
    logic [CONFDW-1:0] w_n;
    logic              w_last, w_sel_fast, w_bit;
    logic [CW-1:0]     w_sel_cnt;
    logic              w_fast_re, w_inter_re, w_take, w_bad_n, w_adv;

    assign w_tidx     = addr_i[IW-1:0];
    assign w_wr       = we_conf_i && !r_busy;
    assign w_n        = r_bl_tbl[r_idx];
    assign w_last     = (CONFDW'(r_idx) == (r_used - 1'b1));
    assign w_sel_fast = (r_fast_rem != '0);
    assign w_sel_cnt  = w_sel_fast ? r_fcnt : r_icnt;
    assign w_bit      = w_sel_fast ? r_fbuf[0] : r_ibuf[0];

    always_ff @(posedge clk) begin
        if (w_wr && addr_i < A_CN)
            r_bl_tbl[w_tidx] <= conf_data_i;
        if (w_wr && addr_i >= A_CN && addr_i < A_USED)
            r_cn_tbl[w_tidx] <= conf_data_i[CNUMW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_fast_re  = 1'b0;
        w_inter_re = 1'b0;
        w_take     = 1'b0;
        w_bad_n    = 1'b0;
        w_adv      = 1'b0;
        unique case (r_state)
            IDLE: if (start_i) w_next = (r_used == '0) ? DONE : LOAD;
            LOAD: begin
                if (w_n == '0 || w_n == 8'd1 || w_n > 8'd15) begin
                    w_bad_n = (w_n != '0);
                    w_adv   = !w_last;
                    w_next  = w_last ? DONE : LOAD;
                end else begin
                    w_next = GATHER;
                end
            end
            GATHER: begin
                if (w_sel_cnt == '0) begin
                    if (w_sel_fast && !fast_empty_i) begin
                        w_fast_re = 1'b1;
                        w_next    = WAIT_F;
                    end else if (!w_sel_fast && !inter_empty_i) begin
                        w_inter_re = 1'b1;
                        w_next     = WAIT_I;
                    end
                end else begin
                    w_take = 1'b1;
                    if (r_gcnt + 4'd1 == r_n) w_next = EMIT;
                end
            end
            WAIT_F, WAIT_I: w_next = GATHER;
            EMIT: if (tone_ready_i) begin
                w_adv  = !w_last;
                w_next = w_last ? DONE : LOAD;
            end
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_used     <= '0;
            r_fastbits <= '0;
            r_fast_rem <= '0;
            r_idx      <= '0;
            r_fbuf     <= '0;
            r_ibuf     <= '0;
            r_fcnt     <= '0;
            r_icnt     <= '0;
            r_n        <= '0;
            r_gcnt     <= '0;
            r_bits     <= '0;
            r_carrier  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            if (r_state == DONE)
                r_busy <= 1'b0;
            else if (r_state == IDLE && start_i)
                r_busy <= 1'b1;
            if ((we_conf_i && r_busy) || w_bad_n)
                r_err <= 1'b1;
            if (w_wr && addr_i == A_USED) r_used <= conf_data_i;
            if (w_wr && addr_i == A_FLO)  r_fastbits[7:0]  <= conf_data_i[7:0];
            if (w_wr && addr_i == A_FHI)  r_fastbits[15:8] <= conf_data_i[7:0];
            if (r_state == IDLE && start_i) begin
                r_idx      <= '0;
                r_fast_rem <= r_fastbits;
                r_fbuf     <= '0;
                r_ibuf     <= '0;
                r_fcnt     <= '0;
                r_icnt     <= '0;
            end
            if (r_state == LOAD) begin
                r_n       <= w_n[3:0];
                r_gcnt    <= '0;
                r_bits    <= '0;
                r_carrier <= r_cn_tbl[r_idx];
            end
            if (w_adv) r_idx <= r_idx + 1'b1;
            // LSB of each FIFO byte is consumed first
            if (w_take) begin
                r_bits[r_gcnt] <= w_bit;
                r_gcnt         <= r_gcnt + 4'd1;
                if (w_sel_fast) begin
                    r_fbuf     <= r_fbuf >> 1;
                    r_fcnt     <= r_fcnt - 1'b1;
                    r_fast_rem <= r_fast_rem - 16'd1;
                end else begin
                    r_ibuf <= r_ibuf >> 1;
                    r_icnt <= r_icnt - 1'b1;
                end
            end
            if (r_state == WAIT_F) begin
                r_fbuf <= fast_data_i;
                r_fcnt <= CW'(DW);
            end
            if (r_state == WAIT_I) begin
                r_ibuf <= inter_data_i;
                r_icnt <= CW'(DW);
            end
        end
    end

    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign err_o         = r_err;
    assign fast_re_o     = w_fast_re;
    assign inter_re_o    = w_inter_re;
    assign tone_valid_o  = (r_state == EMIT);
    assign carrier_num_o = tone_valid_o ? r_carrier : '0;
    assign bits_o        = tone_valid_o ? r_bits : '0;
    assign bitcnt_o      = tone_valid_o ? r_n : '0;

`ifdef TONE_CTRL_READBACK_EN
    logic [CONFDW-1:0] w_rdata;

    always_comb begin
        w_rdata = '0;
        if (addr_i < A_CN)
            w_rdata = r_bl_tbl[w_tidx];
        else if (addr_i < A_USED)
            w_rdata = CONFDW'(r_cn_tbl[w_tidx]);
        else if (addr_i == A_USED)
            w_rdata = r_used;
        else if (addr_i == A_FLO)
            w_rdata = CONFDW'(r_fastbits[7:0]);
        else if (addr_i == A_FHI)
            w_rdata = CONFDW'(r_fastbits[15:8]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          conf_rdata_o <= '0;
        else if (re_conf_i) conf_rdata_o <= w_rdata;
    end
`endif

endmodule

// File: tb/tb_tone_order_ctrl.sv
// Directed bench for tone_order_ctrl: vector table plus hand-written
// multi-cycle sequences (backpressure, skip, underflow, reset, empty symbol).
module tb_tone_order_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        we_conf_i;
    logic [7:0]  addr_i;
    logic [7:0]  conf_data_i;
    logic        start_i;
    logic        busy_o, done_o;
    logic        fast_empty_i, inter_empty_i;
    logic        fast_re_o, inter_re_o;
    logic [7:0]  fast_data_i, inter_data_i;
    logic        tone_valid_o;
    logic        tone_ready_i;
    logic [7:0]  carrier_num_o;
    logic [14:0] bits_o;
    logic [3:0]  bitcnt_o;
    logic        err_o;

    always #5 clk = ~clk;

    tone_order_ctrl dut (
        .clk(clk), .reset(reset),
        .we_conf_i(we_conf_i), .addr_i(addr_i), .conf_data_i(conf_data_i),
        .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .fast_empty_i(fast_empty_i), .inter_empty_i(inter_empty_i),
        .fast_re_o(fast_re_o), .inter_re_o(inter_re_o),
        .fast_data_i(fast_data_i), .inter_data_i(inter_data_i),
        .tone_valid_o(tone_valid_o), .tone_ready_i(tone_ready_i),
        .carrier_num_o(carrier_num_o), .bits_o(bits_o),
        .bitcnt_o(bitcnt_o), .err_o(err_o)
    );

    logic [7:0] fmem [256];
    logic [7:0] imem [256];
    logic [7:0] fwp = 8'd0, frp = 8'd0, iwp = 8'd0, irp = 8'd0;
    int freads = 0, ireads = 0, xfers = 0, dones = 0;
    int checks = 0, errors = 0;

    assign fast_empty_i  = (frp == fwp);
    assign inter_empty_i = (irp == iwp);

    // FIFO models: data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (fast_re_o) begin
            fast_data_i <= fmem[frp];
            frp <= frp + 8'd1;
            freads <= freads + 1;
        end
        if (inter_re_o) begin
            inter_data_i <= imem[irp];
            irp <= irp + 8'd1;
            ireads <= ireads + 1;
        end
        if (tone_valid_o && tone_ready_i) xfers <= xfers + 1;
        if (done_o) dones <= dones + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [7:0] a, input logic [7:0] d);
        we_conf_i = 1'b1;
        addr_i = a;
        conf_data_i = d;
        tick();
        we_conf_i = 1'b0;
    endtask

    task automatic set_fast(input logic [15:0] fb);
        cfg(8'd129, fb[7:0]);
        cfg(8'd130, fb[15:8]);
    endtask

    task automatic push_f(input logic [7:0] b);
        fmem[fwp] = b;
        fwp = fwp + 8'd1;
    endtask

    task automatic push_i(input logic [7:0] b);
        imem[iwp] = b;
        iwp = iwp + 8'd1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_tone(input string name);
        int k;
        for (k = 0; k < 200 && !tone_valid_o; k++) tick();
        if (!tone_valid_o) begin
            checks++;
            errors++;
            $display("FAIL %s timeout waiting for tone_valid_o", name);
        end
    endtask

    task automatic wait_done(input int d0, input string name);
        int k;
        for (k = 0; k < 200 && dones == d0; k++) tick();
        chk(name, dones - d0, 1);
    endtask

    typedef struct {
        logic [7:0]  n;
        logic [15:0] fb;
        logic [15:0] fdat;
        int          nf;
        logic [7:0]  idat;
        int          ni;
        logic [7:0]  cn;
        logic [14:0] ebits;
    } vec_t;

    vec_t vt[5];

    initial begin
        int f0, i0, d0, x0;
        logic [31:0] snap;

        vt[0] = '{8'd6,  16'd4,  16'h000F, 1, 8'h03, 1, 8'd11, 15'h003F};
        vt[1] = '{8'd8,  16'd0,  16'h0000, 0, 8'h5A, 1, 8'd12, 15'h005A};
        vt[2] = '{8'd15, 16'd16, 16'h1234, 2, 8'h00, 0, 8'd13, 15'h1234};
        vt[3] = '{8'd2,  16'd1,  16'h0001, 1, 8'h02, 1, 8'd14, 15'h0001};
        vt[4] = '{8'd10, 16'd3,  16'h0006, 1, 8'hAB, 1, 8'd15, 15'h015E};

        reset = 1'b1;
        we_conf_i = 1'b0;
        addr_i = '0;
        conf_data_i = '0;
        start_i = 1'b0;
        tone_ready_i = 1'b1;
        tick();
        tick();
        chk("reset_outputs",
            {busy_o, done_o, tone_valid_o, fast_re_o, inter_re_o, err_o}, 0);
        chk("reset_bits", {carrier_num_o, bits_o, bitcnt_o}, 0);
        reset = 1'b0;
        tick();

        // Single-tone vectors
        cfg(8'd128, 8'd1);
        for (int v = 0; v < 5; v++) begin
            cfg(8'd0, vt[v].n);
            cfg(8'd64, vt[v].cn);
            set_fast(vt[v].fb);
            if (vt[v].nf > 0) push_f(vt[v].fdat[7:0]);
            if (vt[v].nf > 1) push_f(vt[v].fdat[15:8]);
            if (vt[v].ni > 0) push_i(vt[v].idat);
            f0 = freads;
            i0 = ireads;
            d0 = dones;
            pulse_start();
            wait_tone($sformatf("vec%0d_valid", v));
            chk($sformatf("vec%0d_carrier", v), carrier_num_o, vt[v].cn);
            chk($sformatf("vec%0d_bits", v), bits_o, vt[v].ebits);
            chk($sformatf("vec%0d_cnt", v), bitcnt_o, vt[v].n);
            wait_done(d0, $sformatf("vec%0d_done", v));
            chk($sformatf("vec%0d_freads", v), freads - f0, vt[v].nf);
            chk($sformatf("vec%0d_ireads", v), ireads - i0, vt[v].ni);
        end

        // Two tones sharing one fast byte
        cfg(8'd0, 8'd4);
        cfg(8'd1, 8'd4);
        cfg(8'd64, 8'd5);
        cfg(8'd65, 8'd6);
        cfg(8'd128, 8'd2);
        set_fast(16'd8);
        push_f(8'hA5);
        f0 = freads;
        i0 = ireads;
        d0 = dones;
        pulse_start();
        chk("two_busy", busy_o, 1);
        wait_tone("two_t0");
        chk("two_t0", {carrier_num_o, 1'b0, bits_o, bitcnt_o},
            {8'd5, 1'b0, 15'h5, 4'd4});
        tick();
        wait_tone("two_t1");
        chk("two_t1", {carrier_num_o, 1'b0, bits_o, bitcnt_o},
            {8'd6, 1'b0, 15'hA, 4'd4});
        wait_done(d0, "two_done");
        chk("two_freads", freads - f0, 1);
        chk("two_ireads", ireads - i0, 0);
        chk("two_busy_end", busy_o, 0);

        // Skip with bad bit count, then backpressure
        do_reset();
        chk("err_after_reset", err_o, 0);
        cfg(8'd0, 8'd1);
        cfg(8'd1, 8'd4);
        cfg(8'd65, 8'd9);
        cfg(8'd128, 8'd2);
        set_fast(16'd0);
        push_i(8'h0C);
        tone_ready_i = 1'b0;
        x0 = xfers;
        d0 = dones;
        pulse_start();
        wait_tone("bp_valid");
        chk("bp_err", err_o, 1);
        snap = {carrier_num_o, 1'b0, bits_o, bitcnt_o};
        chk("bp_tone", snap, {8'd9, 1'b0, 15'hC, 4'd4});
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp_stable%0d", c),
                {tone_valid_o, carrier_num_o, 1'b0, bits_o, bitcnt_o},
                {1'b1, snap[27:0]});
        end
        tone_ready_i = 1'b1;
        wait_done(d0, "bp_done");
        chk("bp_xfers", xfers - x0, 1);

        // Inter FIFO underflow stall
        do_reset();
        cfg(8'd0, 8'd8);
        cfg(8'd64, 8'd3);
        cfg(8'd128, 8'd1);
        i0 = ireads;
        d0 = dones;
        pulse_start();
        for (int c = 0; c < 6; c++) tick();
        chk("uf_no_read", ireads - i0, 0);
        chk("uf_no_valid", tone_valid_o, 0);
        push_i(8'h96);
        wait_tone("uf_valid");
        chk("uf_bits", bits_o, 15'h96);
        wait_done(d0, "uf_done");
        chk("uf_ireads", ireads - i0, 1);

        // Config write while busy, then reset mid-gather
        d0 = dones;
        pulse_start();
        for (int c = 0; c < 3; c++) tick();
        cfg(8'd0, 8'd2);
        chk("busy_wr_err", err_o, 1);
        reset = 1'b1;
        #1;
        chk("abort_outputs",
            {busy_o, done_o, tone_valid_o, fast_re_o, inter_re_o, err_o}, 0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        chk("abort_no_done", dones - d0, 0);
        chk("abort_idle_busy", busy_o, 0);

        // Empty symbol: done_o two cycles after start
        cfg(8'd128, 8'd0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("empty_c1", {busy_o, done_o}, 2'b10);
        tick();
        chk("empty_c2", {busy_o, done_o}, 2'b01);
        tick();
        chk("empty_c3", {busy_o, done_o}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tone_order_ctrl.md
TONE_ORDER_CTRL -- requirements
Module: tone_order_ctrl

Interface
REQ-001 Parameters SHALL be: DW 8, FIFO byte width; TABLELEN 64, tone table depth; CONFAW 8, config address width; CONFDW 8, config data width; CNUMW 8, carrier number width; MAXBITNUM 15, maximum bits per tone.
REQ-002 clk  in  1  clock; all logic is rising-edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 we_conf_i  in  1  config write strobe.
REQ-005 addr_i  in  CONFAW  config address.
REQ-006 conf_data_i  in  CONFDW  config write data.
REQ-007 start_i  in  1  one-cycle pulse that starts one DMT symbol.
REQ-008 busy_o  out  1  high from accepted start_i until done_o.
REQ-009 done_o  out  1  one-cycle pulse at symbol end.
REQ-010 fast_empty_i / inter_empty_i  in  1  FIFO empty flags.
REQ-011 fast_re_o / inter_re_o  out  1  FIFO read strobes.
REQ-012 fast_data_i / inter_data_i  in  DW  FIFO read data; valid the cycle after the read strobe.
REQ-013 tone_valid_o  out  1  tone descriptor valid.
REQ-014 tone_ready_i  in  1  encoder accepts the descriptor.
REQ-015 carrier_num_o  out  CNUMW  carrier index of the tone.
REQ-016 bits_o  out  MAXBITNUM  gathered bits; the first bit taken is at bit 0 and unused MSBs are 0.
REQ-017 bitcnt_o  out  4  number of valid bits, 2..15.
REQ-018 err_o  out  1  sticky error flag.

Function
REQ-019 The address map SHALL be: 0..63 BitLoading[i]; 64..127 CarrierNumber[i]; 128 UsedCarrier (0..64); 129 FastBits (bits per symbol from the fast path, 16 bits split as low byte at 129 and high byte at 130); all other addresses are ignored.
REQ-020 Config writes while busy_o=1 SHALL be dropped and SHALL set err_o.
REQ-021 The FSM SHALL have the states IDLE, LOAD, GATHER, WAIT_F, WAIT_I, EMIT and DONE.
REQ-022 IDLE: start_i SHALL move the FSM to LOAD (or straight to DONE if UsedCarrier=0), with tone index=0, fast_remaining=FastBits, both bit buffers cleared and busy_o=1.
REQ-023 start_i while busy_o=1 SHALL be ignored.
REQ-024 LOAD (1 cycle): read BitLoading[idx] into n.
  - n=0: skip the tone.
  - n=1 or n>15: skip the tone and set err_o.
  - Otherwise: clear the gather count and go to GATHER.
  - A skip increments idx, or goes to DONE if idx=UsedCarrier-1.
REQ-025 GATHER SHALL take one bit per cycle, from the fast buffer while fast_remaining>0, otherwise from the inter buffer, and SHALL decrement fast_remaining when the fast path supplies the bit; a tone may therefore mix fast and inter bits.
REQ-026 If the selected buffer holds 0 bits, the block SHALL assert the matching re_o for exactly one cycle when that FIFO's empty flag is 0, and enter WAIT_F or WAIT_I.
  - If the FIFO is empty, it SHALL stay in GATHER with no read strobe.
REQ-027 WAIT_F / WAIT_I SHALL load the 8 data bits into the buffer (the LSB is consumed first) and return to GATHER.
REQ-028 When the gather count reaches n, the FSM SHALL enter EMIT with tone_valid_o=1, carrier_num_o=CarrierNumber[idx], bits_o and bitcnt_o=n.
  - The outputs SHALL be held stable until tone_valid_o and tone_ready_i are both 1.
  - On that transfer it SHALL go to LOAD with idx+1, or to DONE if idx=UsedCarrier-1.
REQ-029 DONE SHALL pulse done_o for 1 cycle, clear busy_o and return to IDLE.
  - Unused buffered bits are discarded.
REQ-030 Tones SHALL be emitted in table index order; CarrierNumber carries the tone ordering.
REQ-031 Minimum latency from LOAD to tone_valid_o SHALL be 1+n cycles, plus 2 cycles per FIFO byte read.

Reset
REQ-032 Reset SHALL force: IDLE; busy_o, done_o, tone_valid_o, fast_re_o, inter_re_o, err_o = 0; bits_o, bitcnt_o, carrier_num_o = 0; UsedCarrier and FastBits = 0; buffers and counters = 0.
REQ-033 The BitLoading and CarrierNumber tables SHALL NOT be reset.
REQ-034 Reset during a symbol SHALL abort it without a done_o pulse.

Configuration
REQ-035 With macro TONE_CTRL_READBACK_EN defined, the block SHALL add ports re_conf_i (in, 1) and conf_rdata_o (out, CONFDW).
  - conf_rdata_o SHALL return the addressed entry one cycle after re_conf_i.
  - Unmapped addresses SHALL read 0.
  - conf_rdata_o SHALL reset to 0.
REQ-036 Without TONE_CTRL_READBACK_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-037 Config: BitLoading[0..1]=4, CarrierNumber[0..1]=5 and 6, UsedCarrier=2, FastBits=8; fast FIFO holds 0xA5, inter FIFO empty; start -> tone(5, bits=0x5, cnt 4), then tone(6, bits=0xA, cnt 4), done_o, exactly one fast read.
REQ-038 Straddle: BitLoading[0]=6, FastBits=4; fast FIFO holds 0x0F, inter FIFO holds 0x03 -> bits_o=0x3F, cnt 6, one read on each FIFO.
REQ-039 Backpressure and skip: tone_ready_i=0 for 5 cycles -> outputs stable throughout, one transfer; BitLoading=1 -> tone skipped, err_o=1.
REQ-040 Underflow and reset: inter FIFO empty mid-gather -> stall with no read strobe until data arrives; reset asserted in GATHER -> all outputs 0, no done_o; UsedCarrier=0 -> done_o two cycles after start.
